// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl
//   Pipeline control for the 5-stage core. It drives the enables of PC, IF/ID
//   and ID/EX. It inserts a one-cycle bubble on a load-use hazard and flushes
//   the front end on a taken branch. It freezes the pipeline while a
//   data-memory access waits for its handshake, and bounds that wait with a
//   timeout.
//
// Handshake: the MEM stage raises dmem_req_mem and holds it until the access
//   completes. dmem_ready high in the same cycle completes the access. While
//   dmem_req_mem is high and dmem_ready is low, the pipeline is frozen
//   (pipe_hold=1). An access that is still not ready after TIMEOUT held cycles
//   is abandoned, and mem_timeout is set.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   rs1_id, rs2_id             source register indices of the ID instruction
//   uses_rs1_id, uses_rs2_id   ID instruction actually reads rs1 / rs2
//   mem_read_ex, rd_ex         EX instruction is a load, and its destination
//   branch_taken_ex            branch/jump resolved taken in EX
//   dmem_req_mem, dmem_ready   data-memory access request / completion
//   pc_write, if_id_write      PC and IF/ID load enables
//   if_id_flush                IF/ID loads a NOP
//   id_ex_bubble               ID/EX control bits loaded as zero
//   pipe_hold                  freeze PC..EX/MEM; MEM/WB loads a bubble
//   mem_timeout                sticky: some access exceeded TIMEOUT
//   stall_count                saturating count of cycles with pc_write=0
//   state_dbg_o                current FSM state (0=RUN, 1=MEM_WAIT)
module hazard_stall_ctrl #(
   parameter int REG_ADDR_W = 5,
   parameter int CNT_W      = 16,
   parameter int TIMEOUT    = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [REG_ADDR_W-1:0] rs1_id,
   input  logic [REG_ADDR_W-1:0] rs2_id,
   input  logic                  uses_rs1_id,
   input  logic                  uses_rs2_id,
   input  logic                  mem_read_ex,
   input  logic [REG_ADDR_W-1:0] rd_ex,
   input  logic                  branch_taken_ex,
   input  logic                  dmem_req_mem,
   input  logic                  dmem_ready,
   output logic                  pc_write,
   output logic                  if_id_write,
   output logic                  if_id_flush,
   output logic                  id_ex_bubble,
   output logic                  pipe_hold,
   output logic                  mem_timeout,
   output logic [CNT_W-1:0]      stall_count,
   output logic                  state_dbg_o
);

   typedef enum logic {RUN = 1'b0, MEM_WAIT = 1'b1} state_t;

   // wait_cnt only needs to reach TIMEOUT-1.
   localparam int WCW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [WCW-1:0] WAIT_LAST = WCW'(TIMEOUT - 1);
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   state_t           state_q, state_d;
   logic [WCW-1:0]   wait_cnt_q, wait_cnt_d;
   logic             timeout_q, timeout_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

   logic hold;
   logic lu;
   logic timeout_hit;

   // With TIMEOUT=0 the wait is unbounded, so the limit compare is masked off.
   assign timeout_hit = (TIMEOUT != 0) && (wait_cnt_q == WAIT_LAST);

   assign lu = mem_read_ex && (rd_ex != '0) &&
               ((uses_rs1_id && (rs1_id == rd_ex)) ||
                (uses_rs2_id && (rs2_id == rd_ex)));

   always_comb begin
      hold = 1'b0;
      if (state_q == RUN) hold = dmem_req_mem && !dmem_ready;
      else                hold = !dmem_ready;
   end

   // Output decode. Reset forcing is combinational, so it takes effect
   // without waiting for a clock edge.
   always_comb begin
      pc_write     = 1'b1;
      if_id_write  = 1'b1;
      if_id_flush  = 1'b0;
      id_ex_bubble = 1'b0;
      pipe_hold    = 1'b0;
      if (!rst_n) begin
         pc_write     = 1'b0;
         if_id_write  = 1'b0;
         if_id_flush  = 1'b1;
         id_ex_bubble = 1'b1;
      end else if (hold) begin
         // Branch and load-use wait until the hold is released.
         pc_write    = 1'b0;
         if_id_write = 1'b0;
         pipe_hold   = 1'b1;
      end else if (branch_taken_ex) begin
         // The ID instruction is on the wrong path, so its hazard is moot.
         if_id_flush  = 1'b1;
         id_ex_bubble = 1'b1;
      end else if (lu) begin
         pc_write     = 1'b0;
         if_id_write  = 1'b0;
         id_ex_bubble = 1'b1;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d     = state_q;
      wait_cnt_d  = wait_cnt_q;
      timeout_d   = timeout_q;
      stall_cnt_d = stall_cnt_q;
      case (state_q)
         RUN: begin
            if (dmem_req_mem && !dmem_ready) begin
               state_d    = MEM_WAIT;
               wait_cnt_d = WCW'(1);
            end
         end
         MEM_WAIT: begin
            if (dmem_ready) begin
               state_d    = RUN;
               wait_cnt_d = '0;
            end else if (timeout_hit) begin
               // The last held cycle. The access is abandoned after this edge.
               state_d    = RUN;
               wait_cnt_d = '0;
               timeout_d  = 1'b1;
            end else begin
               wait_cnt_d = wait_cnt_q + WCW'(1);
            end
         end
         default: state_d = RUN;
      endcase
      if (!pc_write && (stall_cnt_q != CNT_MAX))
         stall_cnt_d = stall_cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= RUN;
         wait_cnt_q  <= '0;
         timeout_q   <= 1'b0;
         stall_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         wait_cnt_q  <= wait_cnt_d;
         timeout_q   <= timeout_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign mem_timeout = timeout_q;
   assign stall_count = stall_cnt_q;
   assign state_dbg_o = state_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Bench for hazard_stall_ctrl: directed hazard/branch/memory-wait/reset steps,
// a counter saturation run and random traffic. Every output is compared each
// cycle against a behavioural model of the control rules.
module tb_hazard_stall_ctrl;
   localparam int RW = 5;
   localparam int CW = 6;
   localparam int TO = 4;
   localparam int CMAX = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [RW-1:0] rs1_id, rs2_id, rd_ex;
   logic          uses_rs1_id, uses_rs2_id, mem_read_ex;
   logic          branch_taken_ex, dmem_req_mem, dmem_ready;
   logic          pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_hold;
   logic          mem_timeout, state_dbg_o;
   logic [CW-1:0] stall_count;

   hazard_stall_ctrl #(.REG_ADDR_W(RW), .CNT_W(CW), .TIMEOUT(TO)) dut (
      .clk(clk), .rst_n(rst_n),
      .rs1_id(rs1_id), .rs2_id(rs2_id),
      .uses_rs1_id(uses_rs1_id), .uses_rs2_id(uses_rs2_id),
      .mem_read_ex(mem_read_ex), .rd_ex(rd_ex),
      .branch_taken_ex(branch_taken_ex),
      .dmem_req_mem(dmem_req_mem), .dmem_ready(dmem_ready),
      .pc_write(pc_write), .if_id_write(if_id_write), .if_id_flush(if_id_flush),
      .id_ex_bubble(id_ex_bubble), .pipe_hold(pipe_hold),
      .mem_timeout(mem_timeout), .stall_count(stall_count),
      .state_dbg_o(state_dbg_o)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int passes = 0;
   int fails  = 0;

   // Model state: whether an access is outstanding, and how many cycles it
   // has already been held.
   bit m_waiting;
   int m_held;
   bit m_to;
   int m_stall;
   bit e_pc, e_ifw, e_fl, e_bub, e_hold;

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) passes++;
      else begin
         fails++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_waiting = 1'b0;
      m_held    = 0;
      m_to      = 1'b0;
      m_stall   = 0;
   endtask

   task automatic compute_expected();
      bit lu;
      e_hold = rst_n && ((!m_waiting && dmem_req_mem && !dmem_ready) ||
                         (m_waiting && !dmem_ready));
      lu = mem_read_ex && (rd_ex != 0) &&
           ((uses_rs1_id && rs1_id == rd_ex) || (uses_rs2_id && rs2_id == rd_ex));
      if (!rst_n)               {e_pc, e_ifw, e_fl, e_bub} = 4'b0011;
      else if (e_hold)          {e_pc, e_ifw, e_fl, e_bub} = 4'b0000;
      else if (branch_taken_ex) {e_pc, e_ifw, e_fl, e_bub} = 4'b1111;
      else if (lu)              {e_pc, e_ifw, e_fl, e_bub} = 4'b0001;
      else                      {e_pc, e_ifw, e_fl, e_bub} = 4'b1100;
   endtask

   // Called at a negedge with inputs already applied. It checks all outputs,
   // crosses one rising edge, and returns at the following negedge.
   task automatic cycle();
      #1;
      compute_expected();
      chk("pc_write",     32'(pc_write),     32'(e_pc));
      chk("if_id_write",  32'(if_id_write),  32'(e_ifw));
      chk("if_id_flush",  32'(if_id_flush),  32'(e_fl));
      chk("id_ex_bubble", 32'(id_ex_bubble), 32'(e_bub));
      chk("pipe_hold",    32'(pipe_hold),    32'(e_hold));
      chk("mem_timeout",  32'(mem_timeout),  32'(m_to));
      chk("stall_count",  32'(stall_count),  m_stall);
      chk("state",        32'(state_dbg_o),  32'(m_waiting));
      @(posedge clk);
      if (rst_n) begin
         if (!e_pc && m_stall < CMAX) m_stall++;
         if (e_hold) begin
            m_held++;
            if (m_held == TO) begin
               m_waiting = 1'b0;
               m_held    = 0;
               m_to      = 1'b1;
            end else begin
               m_waiting = 1'b1;
            end
         end else if (m_waiting) begin
            m_waiting = 1'b0;
            m_held    = 0;
         end
      end
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      rs1_id = '0; rs2_id = '0; rd_ex = '0;
      uses_rs1_id = 1'b0; uses_rs2_id = 1'b0; mem_read_ex = 1'b0;
      branch_taken_ex = 1'b0; dmem_req_mem = 1'b0; dmem_ready = 1'b0;
   endtask

   task automatic apply_reset();
      rst_n = 1'b0;
      model_reset();
      cycle();
      rst_n = 1'b1;
   endtask

   initial begin
      idle_inputs();
      rst_n = 1'b0;
      model_reset();
      cycle();
      cycle();
      rst_n = 1'b1;
      chk("reset_stall", 32'(stall_count), 0);
      chk("reset_timeout", 32'(mem_timeout), 0);

      // 1. Load-use on rs1: one stall cycle.
      mem_read_ex = 1'b1; rd_ex = 5'd5; rs1_id = 5'd5; uses_rs1_id = 1'b1;
      cycle();
      chk("t1_stall", 32'(stall_count), 1);
      mem_read_ex = 1'b0;  // the bubble reaches EX
      cycle();

      // 2. No hazard when rd_ex=0 or when rs1 is not used.
      apply_reset();
      mem_read_ex = 1'b1; rd_ex = 5'd0; rs1_id = 5'd0; uses_rs1_id = 1'b1;
      cycle();
      rd_ex = 5'd5; rs1_id = 5'd5; uses_rs1_id = 1'b0;
      cycle();
      chk("t2_stall", 32'(stall_count), 0);
      // The same hazard through rs2.
      uses_rs2_id = 1'b1; rs2_id = 5'd5;
      cycle();
      idle_inputs();

      // 3. Branch together with load-use: flush wins, no stall.
      apply_reset();
      mem_read_ex = 1'b1; rd_ex = 5'd7; rs2_id = 5'd7; uses_rs2_id = 1'b1;
      branch_taken_ex = 1'b1;
      cycle();
      chk("t3_stall", 32'(stall_count), 0);
      idle_inputs();

      // 4. Memory wait of 3 cycles with a branch pending, then release + flush.
      apply_reset();
      branch_taken_ex = 1'b1; dmem_req_mem = 1'b1; dmem_ready = 1'b0;
      repeat (3) cycle();
      dmem_ready = 1'b1;
      cycle();
      chk("t4_stall", 32'(stall_count), 3);
      idle_inputs();
      cycle();

      // 5. Timeout: ready never arrives, 4 held cycles, and then the flag is sticky.
      apply_reset();
      dmem_req_mem = 1'b1; dmem_ready = 1'b0;
      repeat (TO) cycle();
      dmem_req_mem = 1'b0;  // abandoned access leaves MEM
      chk("t5_timeout", 32'(mem_timeout), 1);
      repeat (3) cycle();
      dmem_req_mem = 1'b1; dmem_ready = 1'b1;
      cycle();
      chk("t5_sticky", 32'(mem_timeout), 1);
      idle_inputs();

      // 6. Reset pulse in the middle of MEM_WAIT, with no clock edge in between.
      dmem_req_mem = 1'b1; dmem_ready = 1'b0;
      cycle();
      cycle();
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      chk("t6_hold", 32'(pipe_hold), 0);
      chk("t6_stall", 32'(stall_count), 0);
      chk("t6_timeout", 32'(mem_timeout), 0);
      chk("t6_state", 32'(state_dbg_o), 0);
      #1;
      rst_n = 1'b1;
      idle_inputs();
      @(negedge clk);
      cycle();

      // Counter saturation: hold the load-use inputs past the counter limit.
      apply_reset();
      mem_read_ex = 1'b1; rd_ex = 5'd3; rs1_id = 5'd3; uses_rs1_id = 1'b1;
      repeat (CMAX + 6) cycle();
      chk("sat_stall", 32'(stall_count), CMAX);
      idle_inputs();

      // Random traffic over a small register space, so that hazards are frequent.
      apply_reset();
      for (int i = 0; i < 400; i++) begin
         rs1_id          = RW'($urandom_range(0, 3));
         rs2_id          = RW'($urandom_range(0, 3));
         rd_ex           = RW'($urandom_range(0, 3));
         uses_rs1_id     = 1'($urandom_range(0, 1));
         uses_rs2_id     = 1'($urandom_range(0, 1));
         mem_read_ex     = 1'($urandom_range(0, 1));
         branch_taken_ex = ($urandom_range(0, 5) == 0);
         dmem_req_mem    = ($urandom_range(0, 2) == 0);
         dmem_ready      = ($urandom_range(0, 3) == 0);
         if (m_waiting) dmem_req_mem = 1'b1;
         if ($urandom_range(0, 99) == 0) apply_reset();
         else cycle();
      end
      idle_inputs();
      cycle();

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

   // Bound the whole run in case the flow of the bench itself stalls.
   initial begin
      #500000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end
endmodule
